// File: rtl/io_interrupt_controller.sv
// Device input FIFO with an interrupt request path toward the processor, plus a single-word OUT holding register.
// Define IO_INT_EN to build in the interrupt FSM; leave it undefined for polling mode (interrupt_signal tied low).
module io_interrupt_controller #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dev_in_data,
    input  logic              dev_in_valid,
    output logic              dev_in_ready,
    output logic [DATA_W-1:0] input_port,
    input  logic              in_read,
    output logic              interrupt_signal,
    input  logic              int_ack,
    input  logic [DATA_W-1:0] out_port,
    input  logic              outport_enable,
    output logic [DATA_W-1:0] dev_out_data,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    output logic              out_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push, pop;

    logic [DATA_W-1:0] dev_out_data_q, dev_out_data_d;
    logic              dev_out_valid_q, dev_out_valid_d;
    logic              out_overrun_q, out_overrun_d;
    logic              out_capture;

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign dev_in_ready = (count_q != FULL_COUNT);
    assign push         = dev_in_valid && dev_in_ready;
    assign pop          = in_read && (count_q != '0);
    assign input_port   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dev_in_data;
        end
    end

    // A new OUT word is taken when the holding register is empty or is being drained this cycle.
    assign out_capture = outport_enable && (!dev_out_valid_q || dev_out_ready);

    always_comb begin
        dev_out_data_d  = dev_out_data_q;
        dev_out_valid_d = dev_out_valid_q;
        out_overrun_d   = out_overrun_q;
        if (out_capture) begin
            dev_out_data_d  = out_port;
            dev_out_valid_d = 1'b1;
        end else if (dev_out_valid_q && dev_out_ready) begin
            dev_out_valid_d = 1'b0;
        end
        if (outport_enable && dev_out_valid_q && !dev_out_ready) begin
            out_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dev_out_data_q  <= '0;
            dev_out_valid_q <= 1'b0;
            out_overrun_q   <= 1'b0;
        end else begin
            dev_out_data_q  <= dev_out_data_d;
            dev_out_valid_q <= dev_out_valid_d;
            out_overrun_q   <= out_overrun_d;
        end
    end

    assign dev_out_data  = dev_out_data_q;
    assign dev_out_valid = dev_out_valid_q;
    assign out_overrun   = out_overrun_q;

`ifdef IO_INT_EN
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0] state_q, state_d;
    logic       irq_q, irq_d;

    // Requests once a word is already sitting in the FIFO; SERVICE drains it without re-requesting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (count_q != '0) state_d = ST_ASSERT;
            ST_ASSERT:  if (int_ack)       state_d = ST_SERVICE;
            ST_SERVICE: if (count_d == '0) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
        irq_d = (state_d == ST_ASSERT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

    assign interrupt_signal = irq_q;
`else
    logic unused_int_ack;
    assign unused_int_ack   = int_ack;
    assign interrupt_signal = 1'b0;
`endif

endmodule

// File: tb/tb_io_interrupt_controller.sv
// Randomized and directed bench for io_interrupt_controller, checked against a queue-based model.
module tb_io_interrupt_controller;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] dev_in_data = '0;
    logic              dev_in_valid = 1'b0;
    logic              dev_in_ready;
    logic [DATA_W-1:0] input_port;
    logic              in_read = 1'b0;
    logic              interrupt_signal;
    logic              int_ack = 1'b0;
    logic [DATA_W-1:0] out_port = '0;
    logic              outport_enable = 1'b0;
    logic [DATA_W-1:0] dev_out_data;
    logic              dev_out_valid;
    logic              dev_out_ready = 1'b0;
    logic              out_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    io_interrupt_controller #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
        .input_port(input_port), .in_read(in_read),
        .interrupt_signal(interrupt_signal), .int_ack(int_ack),
        .out_port(out_port), .outport_enable(outport_enable),
        .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready),
        .out_overrun(out_overrun)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, interrupt as a 3-way mode, OUT path as one held word.
    logic [DATA_W-1:0] m_fifo[$];
    int                m_mode;
    logic [DATA_W-1:0] m_out_data;
    logic              m_out_valid;
    logic              m_overrun;

    always @(posedge clk or negedge rst) begin : model
        int  old_n;
        bit  did_push, did_pop;
        if (!rst) begin
            m_fifo.delete();
            m_mode      = 0;
            m_out_data  = '0;
            m_out_valid = 1'b0;
            m_overrun   = 1'b0;
        end else begin
            old_n    = m_fifo.size();
            did_push = dev_in_valid && (old_n != DEPTH);
            did_pop  = in_read && (old_n != 0);
            if (did_pop)  void'(m_fifo.pop_front());
            if (did_push) m_fifo.push_back(dev_in_data);
`ifdef IO_INT_EN
            if (m_mode == 0 && old_n != 0)            m_mode = 1;
            else if (m_mode == 1 && int_ack)          m_mode = 2;
            else if (m_mode == 2 && m_fifo.size() == 0) m_mode = 0;
`endif
            if (outport_enable && m_out_valid && !dev_out_ready) begin
                m_overrun = 1'b1;
            end else if (outport_enable) begin
                m_out_data  = out_port;
                m_out_valid = 1'b1;
            end else if (m_out_valid && dev_out_ready) begin
                m_out_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en && rst) begin
            check("m_ready", 32'(dev_in_ready), 32'(m_fifo.size() != DEPTH));
            check("m_input_port", 32'(input_port), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
            check("m_irq", 32'(interrupt_signal), 32'(m_mode == 1));
            check("m_out_valid", 32'(dev_out_valid), 32'(m_out_valid));
            check("m_out_data", 32'(dev_out_data), 32'(m_out_data));
            check("m_overrun", 32'(out_overrun), 32'(m_overrun));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dev_in_valid   = 1'b0;
        in_read        = 1'b0;
        int_ack        = 1'b0;
        outport_enable = 1'b0;
        dev_out_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        dev_in_data  = d;
        dev_in_valid = 1'b1;
        step();
        dev_in_valid = 1'b0;
    endtask

    initial begin
        apply_reset();
        check_en = 1'b1;
        check("rst_ready", 32'(dev_in_ready), 32'd1);
        check("rst_input_port", 32'(input_port), 32'd0);
        check("rst_irq", 32'(interrupt_signal), 32'd0);
        check("rst_out_valid", 32'(dev_out_valid), 32'd0);

        // Single push reaches input_port after the edge; interrupt follows one cycle later.
        push_word(16'h1111);
        check("p1_input_port", 32'(input_port), 32'h1111);
        check("p1_irq_early", 32'(interrupt_signal), 32'd0);
        step();
`ifdef IO_INT_EN
        check("p1_irq", 32'(interrupt_signal), 32'd1);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("ack_irq", 32'(interrupt_signal), 32'd0);
        in_read = 1'b1;
        step();
        in_read = 1'b0;
        check("drain_empty", 32'(input_port), 32'd0);
        step();
        check("idle_irq", 32'(interrupt_signal), 32'd0);
        push_word(16'h3333);
        step();
        check("rearm_irq", 32'(interrupt_signal), 32'd1);
`else
        check("poll_irq", 32'(interrupt_signal), 32'd0);
`endif

        // Fill to DEPTH, reject an extra push, then drain in order.
        apply_reset();
        for (int i = 1; i <= 4; i++) push_word(16'hA000 + 16'(i));
        check("full_ready", 32'(dev_in_ready), 32'd0);
        push_word(16'hA005);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 32'(input_port), 32'hA000 + 32'(i));
            in_read = 1'b1;
            step();
            in_read = 1'b0;
        end
        check("drained_port", 32'(input_port), 32'd0);
        check("drained_ready", 32'(dev_in_ready), 32'd1);

        // Steady push+pop at count 2 over ten cycles exercises pointer wrap.
        apply_reset();
        push_word(16'hC001);
        push_word(16'hC002);
        for (int i = 0; i < 10; i++) begin
            dev_in_data  = 16'hBEE0 + 16'(i);
            dev_in_valid = 1'b1;
            in_read      = 1'b1;
            step();
        end
        idle_inputs();
        check("wrap_head", 32'(input_port), 32'hBEE8);
        in_read = 1'b1;
        step();
        check("wrap_last", 32'(input_port), 32'hBEE9);
        step();
        in_read = 1'b0;
        check("wrap_empty", 32'(input_port), 32'd0);

        // OUT path: overrun while stalled, then replace during a completing handshake.
        apply_reset();
        out_port = 16'h00FF; outport_enable = 1'b1; dev_out_ready = 1'b0;
        step();
        out_port = 16'h0F0F;
        step();
        check("ovr_data", 32'(dev_out_data), 32'h00FF);
        check("ovr_flag", 32'(out_overrun), 32'd1);
        out_port = 16'h1234; dev_out_ready = 1'b1;
        step();
        check("swap_data", 32'(dev_out_data), 32'h1234);
        check("swap_valid", 32'(dev_out_valid), 32'd1);
        outport_enable = 1'b0;
        step();
        dev_out_ready = 1'b0;
        check("out_done", 32'(dev_out_valid), 32'd0);
        check("ovr_sticky", 32'(out_overrun), 32'd1);

        // Asynchronous reset with three words queued (and interrupt asserted when enabled).
        apply_reset();
        for (int i = 0; i < 3; i++) push_word(16'h5500 + 16'(i));
`ifdef IO_INT_EN
        begin
            int waited = 0;
            while (!interrupt_signal && waited < 10) begin
                step();
                waited++;
            end
            check("arst_irq_up", 32'(interrupt_signal), 32'd1);
        end
`endif
        #3 rst = 1'b0;
        #1;
        check("arst_ready", 32'(dev_in_ready), 32'd1);
        check("arst_port", 32'(input_port), 32'd0);
        check("arst_irq", 32'(interrupt_signal), 32'd0);
        check("arst_out", 32'({dev_out_valid, out_overrun, dev_out_data}), 32'd0);
        step();
        rst = 1'b1;

        // Random traffic; periodic resets keep the sticky overrun from hiding later behaviour.
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int c = 0; c < 200; c++) begin
                dev_in_data    = 16'($urandom);
                dev_in_valid   = ($urandom_range(0, 9) < 6);
                in_read        = ($urandom_range(0, 9) < 4);
                int_ack        = ($urandom_range(0, 9) < 3);
                out_port       = 16'($urandom);
                outport_enable = ($urandom_range(0, 9) < (r < 2 ? 2 : 5));
                dev_out_ready  = ($urandom_range(0, 9) < (r < 2 ? 8 : 4));
                step();
            end
        end
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
